action_scheduler: RTL and testbench
===================================

ACTION_SCHEDULER -- requirements
Module: action_scheduler

Interface
REQ-001 Parameter BASE_PERIOD, 100_000_000, gravity period in clk cycles at level 0.
REQ-002 Parameter MIN_PERIOD, 10_000_000, lower clamp on gravity period.
REQ-003 Parameter STEP, 9_000_000, period reduction per level.
REQ-004 Parameter WAIT_TIMEOUT, 1_000_000, max cycles in WAIT before abort.
REQ-005 clk  in  1  system clock; one clock domain.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 in_ctrl  in  control_type  head of user command queue; NONE = empty.
REQ-008 in_pop  out  1  one-cycle pulse consuming in_ctrl.
REQ-009 eng_ctrl  out  control_type  action presented to game engine.
REQ-010 eng_start  out  1  one-cycle pulse launching eng_ctrl.
REQ-011 eng_done  in  1  engine completed current action.
REQ-012 level  in  4  game level, 0..15.
REQ-013 pause  in  1  freeze gravity and command issue.
REQ-014 game_over  in  1  stop scheduling permanently.
REQ-015 busy  out  1  high when state != IDLE.
REQ-016 err  out  1  sticky engine-timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, HALT.
REQ-018 Gravity counter, 32-bit, SHALL increment each cycle unless pause=1 or state=HALT; on reaching period-1 it SHALL reload 0 and set grav_pend (saturating, second tick while set is absorbed).
REQ-019 IDLE priority: game_over -> HALT; else pause -> stay, no pop; else grav_pend -> latch DOWN, clear grav_pend, -> ISSUE; else in_ctrl != NONE -> latch in_ctrl, in_pop=1 same cycle, -> ISSUE.
REQ-020 Gravity tick and pending user command in same IDLE cycle: DOWN served first, in_pop stays 0, user command served on next IDLE.
REQ-021 ISSUE SHALL last exactly one cycle with eng_start=1, then -> WAIT; eng_start SHALL occur the cycle after in_pop (or after grav selection).
REQ-022 eng_ctrl SHALL hold latched action during ISSUE and WAIT, NONE in IDLE/HALT.
REQ-023 Issuing DOWN or DROP (either source) SHALL zero the gravity counter and clear grav_pend in the ISSUE cycle.
REQ-024 WAIT: eng_done=1 -> IDLE; timeout counter reaching WAIT_TIMEOUT -> err=1, -> IDLE; eng_done outside WAIT ignored.
REQ-025 HALT SHALL be exited only by reset; no pops, no starts.
REQ-026 level change mid-count SHALL apply immediately; if counter >= new period-1, tick on next cycle.

Reset
REQ-027 reset_n=0 SHALL asynchronously force state=IDLE, counters=0, grav_pend=0, err=0, in_pop=0, eng_start=0, eng_ctrl=NONE, busy=0, including mid-WAIT.

Configuration
REQ-028 Macro GRAVITY_SPEEDUP_EN defined: period = BASE_PERIOD - level*STEP, clamped to MIN_PERIOD, computed without underflow.
REQ-029 Macro undefined: period = BASE_PERIOD; level ignored.

Structure
REQ-030 control_type (NONE, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV) and state enum SHALL live in shared package control_pkg.
REQ-031 Gravity counter and period computation SHALL be sub-module gravity_timer (outputs tick; inputs clear, pause, level).

Verification (BASE_PERIOD=20, MIN_PERIOD=4, STEP=4, WAIT_TIMEOUT=8)
REQ-032 in_ctrl=LEFT, eng_done 3 cycles after start -> in_pop 1 cycle, next cycle eng_start with eng_ctrl=LEFT, IDLE after done.
REQ-033 no input, eng_done immediate -> eng_start with DOWN every 20 cycles.
REQ-034 tick coincident with in_ctrl=ROTATE -> DOWN issued, in_pop=0; ROTATE issued after DOWN done.
REQ-035 level=5 -> period 4 with GRAVITY_SPEEDUP_EN, 20 without.
REQ-036 eng_done never asserted -> err=1 after 8 WAIT cycles, IDLE, next command served normally.
REQ-037 reset_n low during WAIT -> all outputs reset without clock edge; game_over in IDLE -> HALT, no further in_pop/eng_start.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types for the action scheduler: engine command codes and scheduler states.
// Also holds the gravity counter width and a helper that classifies commands.
package control_pkg;

    typedef enum logic [2:0] {
        NONE,
        LEFT,
        RIGHT,
        DOWN,
        DROP,
        HOLD,
        ROTATE,
        ROTATE_REV
    } control_type;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HALT
    } sched_state_t;

    localparam int GRAV_CNT_W = 32;

    // Commands that move the piece downward restart the gravity interval.
    function automatic logic resets_gravity(input control_type c);
        return (c == DOWN) || (c == DROP);
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity interval counter: pulses tick once per gravity period while running.
// Define GRAVITY_SPEEDUP_EN to shorten the period with level; otherwise level is ignored.
module gravity_timer
    import control_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 100_000_000,
    parameter int unsigned MIN_PERIOD  = 10_000_000,
    parameter int unsigned STEP        = 9_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       pause,
    input  logic [3:0] level,
    output logic       tick
);

    logic [GRAV_CNT_W-1:0] cnt_q;
    logic [GRAV_CNT_W-1:0] period;

`ifdef GRAVITY_SPEEDUP_EN
    // Wide intermediate keeps level*STEP from wrapping; the clamp avoids underflow.
    function automatic logic [GRAV_CNT_W-1:0] clamp_period(input logic [3:0] lvl);
        logic [39:0] cut;
        cut = 40'(lvl) * 40'(STEP);
        if (cut + 40'(MIN_PERIOD) >= 40'(BASE_PERIOD)) begin
            return GRAV_CNT_W'(MIN_PERIOD);
        end
        return GRAV_CNT_W'(BASE_PERIOD) - cut[GRAV_CNT_W-1:0];
    endfunction

    assign period = clamp_period(level);
`else
    logic unused_level;
    assign unused_level = ^level;
    assign period       = GRAV_CNT_W'(BASE_PERIOD);
`endif

    // A level change that leaves the count past the new limit fires immediately.
    assign tick = !pause && (cnt_q >= period - GRAV_CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (!pause) begin
            cnt_q <= tick ? '0 : cnt_q + GRAV_CNT_W'(1);
        end
    end

endmodule

// File: rtl/action_scheduler.sv
// Serialises user commands and gravity DOWN steps into one-at-a-time engine actions.
// Build option GRAVITY_SPEEDUP_EN (see gravity_timer) makes the gravity period level-dependent.
module action_scheduler
    import control_pkg::*;
#(
    parameter int unsigned BASE_PERIOD  = 100_000_000,
    parameter int unsigned MIN_PERIOD   = 10_000_000,
    parameter int unsigned STEP         = 9_000_000,
    parameter int unsigned WAIT_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  control_type in_ctrl,
    output logic        in_pop,
    output control_type eng_ctrl,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic [3:0]  level,
    input  logic        pause,
    input  logic        game_over,
    output logic        busy,
    output logic        err
);

    localparam logic [31:0] WAIT_LAST = 32'(WAIT_TIMEOUT - 1);

    sched_state_t state_q, state_d;
    control_type  act_q, act_d;
    logic [31:0]  wcnt_q, wcnt_d;
    logic         grav_pend_q, grav_pend_d;
    logic         err_q, err_d;
    logic         pop_c;
    logic         clear_c;
    logic         grav_tick;
    logic         grav_hold;

    assign grav_hold = pause || (state_q == HALT);

    gravity_timer #(
        .BASE_PERIOD(BASE_PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .STEP       (STEP)
    ) u_gravity (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (clear_c),
        .pause  (grav_hold),
        .level  (level),
        .tick   (grav_tick)
    );

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        wcnt_d      = wcnt_q;
        err_d       = err_q;
        pop_c       = 1'b0;
        clear_c     = 1'b0;
        grav_pend_d = grav_pend_q || grav_tick;

        unique case (state_q)
            IDLE: begin
                if (game_over) begin
                    state_d = HALT;
                end else if (!pause) begin
                    // Gravity outranks a waiting user command; that command stays queued.
                    if (grav_pend_q || grav_tick) begin
                        act_d   = DOWN;
                        state_d = ISSUE;
                    end else if (in_ctrl != NONE) begin
                        act_d   = in_ctrl;
                        pop_c   = 1'b1;
                        state_d = ISSUE;
                    end
                end
                // Clearing here makes the counter read zero during the ISSUE cycle.
                clear_c = (state_d == ISSUE) && resets_gravity(act_d);
            end
            ISSUE: begin
                state_d = WAIT;
                wcnt_d  = '0;
            end
            WAIT: begin
                if (eng_done) begin
                    state_d = IDLE;
                end else if (wcnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_c) begin
            grav_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            act_q       <= NONE;
            wcnt_q      <= '0;
            grav_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_q       <= act_d;
            wcnt_q      <= wcnt_d;
            grav_pend_q <= grav_pend_d;
            err_q       <= err_d;
        end
    end

    // in_pop is decoded from live inputs, so it is masked while reset is asserted.
    assign in_pop    = pop_c && reset_n;
    assign eng_start = (state_q == ISSUE);
    assign eng_ctrl  = ((state_q == ISSUE) || (state_q == WAIT)) ? act_q : NONE;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_action_scheduler.sv
// Bench for action_scheduler: directed scenarios plus a randomized run against a timing model.
module tb_action_scheduler;
    import control_pkg::*;

    localparam int BASE = 20;
    localparam int MINP = 4;
    localparam int STP  = 4;
    localparam int WTO  = 8;
`ifdef GRAVITY_SPEEDUP_EN
    localparam int SPEED_STEP = STP;
`else
    localparam int SPEED_STEP = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    control_type in_ctrl;
    logic        in_pop;
    control_type eng_ctrl;
    logic        eng_start;
    logic        eng_done;
    logic [3:0]  level;
    logic        pause;
    logic        game_over;
    logic        busy;
    logic        err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    action_scheduler #(
        .BASE_PERIOD (BASE),
        .MIN_PERIOD  (MINP),
        .STEP        (STP),
        .WAIT_TIMEOUT(WTO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_ctrl  (in_ctrl),
        .in_pop   (in_pop),
        .eng_ctrl (eng_ctrl),
        .eng_start(eng_start),
        .eng_done (eng_done),
        .level    (level),
        .pause    (pause),
        .game_over(game_over),
        .busy     (busy),
        .err      (err)
    );

    // Gravity period in cycles for a given level.
    function automatic int ref_period(input int lvl);
        int p;
        p = BASE - lvl * SPEED_STEP;
        if (p < MINP) p = MINP;
        return p;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the drive point of cycle 0 (first cycle after release).
    task automatic do_reset();
        reset_n   = 1'b0;
        in_ctrl   = NONE;
        eng_done  = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
        level     = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b1;
        in_ctrl   = LEFT;
        eng_done  = 1'b0;
        pause     = 1'b0;
        game_over = 1'b0;
        level     = 4'd0;
        #1 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (eng_start !== 1'b0) begin fails++; $display("FAIL reset_eng_start: got %b want 0", eng_start); end
        checks++; if (eng_ctrl !== NONE) begin fails++; $display("FAIL reset_eng_ctrl: got %0d want %0d", eng_ctrl, NONE); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL reset_in_pop: got %b want 0", in_pop); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_pop !== 1'b0) begin fails++; $display("FAIL reset_held: busy=%b in_pop=%b want 0/0", busy, in_pop); end
    endtask

    task automatic test_user_cmd();
        for (int it = 0; it < 4; it++) begin
            control_type cmd;
            int d;
            cmd = control_type'(3'($urandom_range(1, 7)));
            d   = $urandom_range(1, 4);
            if (it == 0) begin
                cmd = LEFT;
                d   = 3;
            end
            do_reset();
            in_ctrl = cmd;
            @(negedge clk);
            checks++; if (in_pop !== 1'b1 || eng_start !== 1'b0) begin fails++; $display("FAIL user_pop[%0d]: in_pop=%b eng_start=%b want 1/0", it, in_pop, eng_start); end
            next_cycle();
            in_ctrl = NONE;
            @(negedge clk);
            checks++; if (eng_start !== 1'b1 || eng_ctrl !== cmd) begin fails++; $display("FAIL user_start[%0d]: start=%b ctrl=%0d want 1/%0d", it, eng_start, eng_ctrl, cmd); end
            checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL user_pop_once[%0d]: got %b want 0", it, in_pop); end
            for (int k = 2; k <= 1 + d; k++) begin
                next_cycle();
                eng_done = (k == 1 + d);
                @(negedge clk);
                checks++; if (busy !== 1'b1 || eng_ctrl !== cmd || eng_start !== 1'b0) begin fails++; $display("FAIL user_wait[%0d,%0d]: busy=%b ctrl=%0d start=%b want 1/%0d/0", it, k, busy, eng_ctrl, eng_start, cmd); end
            end
            next_cycle();
            eng_done = 1'b0;
            @(negedge clk);
            checks++; if (busy !== 1'b0 || eng_ctrl !== NONE) begin fails++; $display("FAIL user_idle[%0d]: busy=%b ctrl=%0d want 0/%0d", it, busy, eng_ctrl, NONE); end
        end
    endtask

    task automatic test_gravity_period();
        int lvls[3] = '{0, 5, 15};
        foreach (lvls[i]) begin
            int per;
            int starts[$];
            per = ref_period(lvls[i]);
            do_reset();
            level    = 4'(lvls[i]);
            eng_done = 1'b1;
            for (int x = 0; x <= 3 * per + 3; x++) begin
                @(negedge clk);
                if (eng_start === 1'b1) begin
                    starts.push_back(x);
                    checks++; if (eng_ctrl !== DOWN) begin fails++; $display("FAIL grav_ctrl[L%0d,c%0d]: got %0d want %0d", lvls[i], x, eng_ctrl, DOWN); end
                end
                checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL grav_no_pop[L%0d,c%0d]: got %b want 0", lvls[i], x, in_pop); end
                next_cycle();
            end
            checks++;
            if (starts.size() < 3) begin
                fails++; $display("FAIL grav_count[L%0d]: got %0d starts want 3", lvls[i], starts.size());
            end else if (starts[0] != per || starts[1] - starts[0] != per || starts[2] - starts[1] != per) begin
                fails++; $display("FAIL grav_period[L%0d]: starts %0d,%0d,%0d want %0d,%0d,%0d", lvls[i], starts[0], starts[1], starts[2], per, 2 * per, 3 * per);
            end
        end
        eng_done = 1'b0;
        level    = 4'd0;
    endtask

    task automatic test_pause();
        int first;
        first = -1;
        do_reset();
        pause    = 1'b1;
        in_ctrl  = LEFT;
        eng_done = 1'b1;
        for (int x = 0; x < 60; x++) begin
            if (x == 10) begin
                pause   = 1'b0;
                in_ctrl = NONE;
            end
            @(negedge clk);
            if (x < 10) begin
                checks++; if (in_pop !== 1'b0 || eng_start !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL pause_hold[c%0d]: pop=%b start=%b busy=%b want 0/0/0", x, in_pop, eng_start, busy); end
            end
            if (eng_start === 1'b1 && first < 0) first = x;
            next_cycle();
        end
        checks++; if (first != 10 + BASE) begin fails++; $display("FAIL pause_first_down: got cycle %0d want %0d", first, 10 + BASE); end
        eng_done = 1'b0;
    endtask

    task automatic test_collision();
        do_reset();
        eng_done = 1'b1;
        for (int x = 0; x <= 24; x++) begin
            in_ctrl = (x >= 19 && x <= 22) ? ROTATE : NONE;
            @(negedge clk);
            if (x == 19) begin
                checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL coll_no_pop: got %b want 0", in_pop); end
            end
            if (x == 20) begin
                checks++; if (eng_start !== 1'b1 || eng_ctrl !== DOWN) begin fails++; $display("FAIL coll_down: start=%b ctrl=%0d want 1/%0d", eng_start, eng_ctrl, DOWN); end
                checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL coll_pop_in_issue: got %b want 0", in_pop); end
            end
            if (x == 22) begin
                checks++; if (in_pop !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL coll_rot_pop: pop=%b busy=%b want 1/0", in_pop, busy); end
            end
            if (x == 23) begin
                checks++; if (eng_start !== 1'b1 || eng_ctrl !== ROTATE) begin fails++; $display("FAIL coll_rot_start: start=%b ctrl=%0d want 1/%0d", eng_start, eng_ctrl, ROTATE); end
            end
            next_cycle();
        end
        eng_done = 1'b0;
        in_ctrl  = NONE;
    endtask

    task automatic test_timeout();
        do_reset();
        for (int x = 0; x <= 13; x++) begin
            in_ctrl  = (x == 0) ? RIGHT : (x == 10) ? LEFT : NONE;
            eng_done = (x == 12);
            @(negedge clk);
            if (x == 0) begin
                checks++; if (in_pop !== 1'b1) begin fails++; $display("FAIL to_pop: got %b want 1", in_pop); end
            end
            if (x == 1) begin
                checks++; if (eng_start !== 1'b1 || eng_ctrl !== RIGHT) begin fails++; $display("FAIL to_start: start=%b ctrl=%0d want 1/%0d", eng_start, eng_ctrl, RIGHT); end
            end
            if (x >= 2 && x <= 9) begin
                checks++; if (busy !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL to_wait[c%0d]: busy=%b err=%b want 1/0", x, busy, err); end
            end
            if (x == 10) begin
                checks++; if (busy !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL to_abort: busy=%b err=%b want 0/1", busy, err); end
                checks++; if (in_pop !== 1'b1) begin fails++; $display("FAIL to_next_pop: got %b want 1", in_pop); end
            end
            if (x == 11) begin
                checks++; if (eng_start !== 1'b1 || eng_ctrl !== LEFT) begin fails++; $display("FAIL to_next_start: start=%b ctrl=%0d want 1/%0d", eng_start, eng_ctrl, LEFT); end
            end
            if (x == 13) begin
                checks++; if (busy !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL to_sticky: busy=%b err=%b want 0/1", busy, err); end
            end
            next_cycle();
        end
        eng_done = 1'b0;
    endtask

    // Runs straight after test_timeout, so err is still set when reset hits mid-WAIT.
    task automatic test_async_reset_halt();
        in_ctrl = HOLD;
        next_cycle();
        in_ctrl = LEFT;
        next_cycle();
        checks++; if (busy !== 1'b1 || eng_ctrl !== HOLD) begin fails++; $display("FAIL ar_in_wait: busy=%b ctrl=%0d want 1/%0d", busy, eng_ctrl, HOLD); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || eng_ctrl !== NONE || eng_start !== 1'b0) begin fails++; $display("FAIL ar_outputs: busy=%b ctrl=%0d start=%b want 0/%0d/0", busy, eng_ctrl, eng_start, NONE); end
        checks++; if (err !== 1'b0 || in_pop !== 1'b0) begin fails++; $display("FAIL ar_err_pop: err=%b pop=%b want 0/0", err, in_pop); end
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        game_over = 1'b1;
        in_ctrl   = LEFT;
        @(negedge clk);
        checks++; if (in_pop !== 1'b0) begin fails++; $display("FAIL halt_entry_pop: got %b want 0", in_pop); end
        next_cycle();
        game_over = 1'b0;
        for (int x = 1; x <= 45; x++) begin
            eng_done = (x % 5 == 0);
            @(negedge clk);
            checks++; if (busy !== 1'b1 || in_pop !== 1'b0 || eng_start !== 1'b0) begin fails++; $display("FAIL halt_hold[c%0d]: busy=%b pop=%b start=%b want 1/0/0", x, busy, in_pop, eng_start); end
            next_cycle();
        end
        eng_done = 1'b0;
        in_ctrl  = NONE;
    endtask

    // Random command queue and engine latency, checked against gravity due-time arithmetic.
    task automatic test_back_to_back();
        control_type q[$];
        control_type cur_act;
        int last_clear;
        int idle_at;
        int done_at;
        bit gflag;
        bit issue_now;
        last_clear = 0;
        idle_at    = 0;
        done_at    = -1;
        gflag      = 1'b0;
        issue_now  = 1'b0;
        cur_act    = NONE;
        do_reset();
        for (int x = 0; x < 600; x++) begin
            int per;
            bit exp_pop;
            bit sched;
            control_type act;
            control_type exp_ctrl;
            if (x % 37 == 5) level = 4'($urandom_range(0, 15));
            in_ctrl  = (q.size() > 0) ? q[0] : NONE;
            eng_done = (x == done_at) || ((x >= idle_at || issue_now) && ($urandom_range(0, 7) == 0));
            @(negedge clk);
            per = ref_period(int'(level));
            if (x - last_clear >= per - 1) gflag = 1'b1;
            exp_ctrl = (x < idle_at) ? cur_act : NONE;
            checks++; if (busy !== (x < idle_at)) begin fails++; $display("FAIL rnd_busy[c%0d]: got %b want %b", x, busy, (x < idle_at)); end
            checks++; if (eng_start !== issue_now) begin fails++; $display("FAIL rnd_start[c%0d]: got %b want %b", x, eng_start, issue_now); end
            checks++; if (eng_ctrl !== exp_ctrl) begin fails++; $display("FAIL rnd_ctrl[c%0d]: got %0d want %0d", x, eng_ctrl, exp_ctrl); end
            exp_pop = 1'b0;
            sched   = 1'b0;
            act     = NONE;
            if (x >= idle_at) begin
                if (gflag) begin
                    act   = DOWN;
                    sched = 1'b1;
                end else if (q.size() > 0) begin
                    act     = q.pop_front();
                    exp_pop = 1'b1;
                    sched   = 1'b1;
                end
            end
            checks++; if (in_pop !== exp_pop) begin fails++; $display("FAIL rnd_pop[c%0d]: got %b want %b", x, in_pop, exp_pop); end
            checks++; if (err !== 1'b0) begin fails++; $display("FAIL rnd_err[c%0d]: got %b want 0", x, err); end
            issue_now = sched;
            if (sched) begin
                cur_act = act;
                done_at = x + 1 + $urandom_range(1, 5);
                idle_at = done_at + 1;
                if (act == DOWN || act == DROP) begin
                    last_clear = x + 1;
                    gflag      = 1'b0;
                end
            end
            if (q.size() < 2 && $urandom_range(0, 3) == 0) q.push_back(control_type'(3'($urandom_range(1, 7))));
            next_cycle();
        end
        in_ctrl  = NONE;
        eng_done = 1'b0;
        level    = 4'd0;
    endtask

    initial begin
        test_reset();
        test_user_cmd();
        test_gravity_period();
        test_pause();
        test_collision();
        test_timeout();
        test_async_reset_halt();
        test_back_to_back();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
